event_fifo_level_int: RTL and testbench
=======================================

# event_fifo_level_int

Buffered, parametrised successor of the single-entry event-to-level interrupt converter in the FC subsystem. Handshaked events are pushed into a FIFO of depth FIFO_DEPTH. The FIFO drains through an APB-read data register. A level interrupt is raised while the fill count meets a programmable threshold. It adds occupancy status, interrupt enable, threshold coalescing and flush, so that bursts of events are never lost.

## Interface
- EVENT_WIDTH, 8, event id width; legal range 1..31.
- FIFO_DEPTH, 4, number of buffered events; legal range 2..255, power of two not required.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is synchronous and active-low.
- ctrl  APB_BUS.Slave  32-bit  register access. Decode uses paddr[7:0].
- event_data_i  in  EVENT_WIDTH  event id.
- event_valid_i  in  1  event offered.
- event_ready_o  out  1  event accepted when valid&&ready at a rising edge.
- int_lvl_o  out  1  level interrupt to the FC.

## Operation
- Storage is a circular buffer with write pointer, read pointer and count. CW = $clog2(FIFO_DEPTH+1).
- Pointers wrap from FIFO_DEPTH-1 to 0, including for non-power-of-two depths.
- event_ready_o = (count != FIFO_DEPTH). It is driven from registered count only and has no combinational path from the APB pop.
- The APB access phase is psel&&penable. pready is constant 1 and every access completes in one cycle.
- Register map:
  - 0x00 EVENT_DATA (RO): prdata[EVENT_WIDTH-1:0] is the head entry and prdata[31] is 1 when the FIFO is non-empty. A read pops the head if non-empty. If empty, it returns 0 and nothing changes.
  - 0x04 STATUS (RO): [CW-1:0] count, [16] empty, [17] full.
  - 0x08 CTRL (RW): [0] IRQ_EN (reset 1), [15:8] THRESHOLD (reset 1), [31] FLUSH. FLUSH is write-1, self-clearing and reads 0. Unused bits read 0.
- Effective threshold: THRESHOLD=0 is treated as 1, and THRESHOLD>FIFO_DEPTH is treated as FIFO_DEPTH.
- int_lvl_o (registered) = IRQ_EN && (count_next >= effective threshold).
- Error responses: pslverr=1 for an unmapped offset, or for a write to 0x00 or 0x04. Such writes have no side effect. Reads of unmapped offsets return 0.
- Simultaneous push and pop in a non-empty FIFO: count is unchanged, the head advances and the new entry is written at the tail.
- Push with a read while empty: the read returns 0 with no pop, and the push is stored (count becomes 1).
- Push while full: not possible, because ready=0. A pop in the same cycle does not make ready high until the next cycle.
- FLUSH write together with an accepted push: pointers and count clear, then the pushed event is stored, giving count=1.
- A FLUSH write coincident with an EVENT_DATA read cannot occur, since there is a single APB port.
- Reset at any point, including mid-burst: all state is discarded on the next edge with rst_ni=0.

## Timing
- Reset values: event_ready_o=1, int_lvl_o=0, count=0, pointers=0, IRQ_EN=1, THRESHOLD=1, prdata=0 when no access is in progress, pslverr=0.
- Push accepted at edge N: count and STATUS update at N, and int_lvl_o reflects the new count at edge N, i.e. the same edge with zero added latency.
- EVENT_DATA read in the access cycle: prdata is combinational from the current head. The pop takes effect at the closing edge, and int_lvl_o may drop at that same edge.
- CTRL write at edge N: the new IRQ_EN and THRESHOLD values are applied to int_lvl_o at edge N. FLUSH clears count at edge N.
- Full → ready=0 in the cycle after the filling edge. After a pop at edge M, ready=1 from edge M.

## Test plan
- FIFO_DEPTH=4: push ids 0x11,0x22,0x33,0x44 back-to-back → ready drops after the 4th and int is high from the 1st. Four EVENT_DATA reads return 0x80000011..0x80000044 in order. A 5th read returns 0 and int=0.
- Threshold: write CTRL THRESHOLD=3 → int stays 0 after 2 pushes and rises at the edge of the 3rd push. One read drops int at that read's edge.
- Wrap and non-power-of-two depth: FIFO_DEPTH=3, run 10 interleaved push/pop cycles including simultaneous ones → data order is preserved and count never exceeds 3.
- Simultaneous events:
  - push and read on an empty FIFO → read returns 0, count=1.
  - push and FLUSH → count=1 holding the new id.
- IRQ_EN=0 with 2 queued events → int=0. Writing IRQ_EN=1 → int=1 at the write edge.
- Errors and reset:
  - write to 0x00 → pslverr=1, FIFO unchanged.
  - read of 0x0C → pslverr=1, prdata=0.
  - rst_ni low for one edge while full → count=0, ready=1, int=0, CTRL restored to 0x0000_0101.

Source files
------------

// File: rtl/event_fifo_level_int.sv
// Event FIFO with an APB drain register and a threshold-driven level interrupt.
// Handshaked event ids queue up; the FC pops them by reading EVENT_DATA.
module event_fifo_level_int #(
    parameter int EVENT_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [7:0]             paddr_i,
    input  logic [31:0]            pwdata_i,
    input  logic                   pwrite_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    output logic [31:0]            prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    input  logic [EVENT_WIDTH-1:0] event_data_i,
    input  logic                   event_valid_i,
    output logic                   event_ready_o,
    output logic                   int_lvl_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;

    logic [EVENT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
    logic [CW-1:0]          count_q, count_d, eff_thr;
    logic                   irq_en_q, irq_en_d;
    logic [7:0]             threshold_q, threshold_d;
    logic                   int_q, int_d;

    logic access, rd_access, wr_access;
    logic fifo_empty, fifo_full;
    logic push, pop, ctrl_wr, flush;

    logic unused_pwdata;
    assign unused_pwdata = ^{pwdata_i[30:16], pwdata_i[7:1]};

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign access    = psel_i && penable_i;
    assign rd_access = access && !pwrite_i;
    assign wr_access = access && pwrite_i;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);

    // Ready depends only on the registered count, so a pop never opens it early.
    assign event_ready_o = !fifo_full;
    assign push          = event_valid_i && event_ready_o;
    assign pop           = rd_access && (paddr_i == ADDR_DATA) && !fifo_empty;
    assign ctrl_wr       = wr_access && (paddr_i == ADDR_CTRL);
    assign flush         = ctrl_wr && pwdata_i[31];

    // A flush and a push on the same edge store the event as the sole entry.
    assign wr_addr = flush ? '0 : wr_ptr_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
            count_d  = count_q - CW'(1);
        end

        if (push) begin
            wr_ptr_d = next_ptr(wr_addr);
            count_d  = count_d + CW'(1);
        end

        if (ctrl_wr) begin
            irq_en_d    = pwdata_i[0];
            threshold_d = pwdata_i[15:8];
        end
    end

    always_comb begin
        if (threshold_d == 8'd0) begin
            eff_thr = CW'(1);
        end else if ({1'b0, threshold_d} > 9'(FIFO_DEPTH)) begin
            eff_thr = DEPTH_C;
        end else begin
            eff_thr = CW'(threshold_d);
        end
        int_d = irq_en_d && (count_d >= eff_thr);
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            irq_en_q    <= 1'b1;
            threshold_q <= 8'd1;
            int_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            int_q       <= int_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_addr] <= event_data_i;
        end
    end

    assign int_lvl_o = int_q;
    assign pready_o  = 1'b1;

    always_comb begin
        prdata_o  = '0;
        pslverr_o = 1'b0;
        if (access) begin
            case (paddr_i)
                ADDR_DATA: begin
                    if (pwrite_i) begin
                        pslverr_o = 1'b1;
                    end else if (!fifo_empty) begin
                        prdata_o[31]              = 1'b1;
                        prdata_o[EVENT_WIDTH-1:0] = mem_q[rd_ptr_q];
                    end
                end
                ADDR_STATUS: begin
                    if (pwrite_i) begin
                        pslverr_o = 1'b1;
                    end else begin
                        prdata_o[CW-1:0] = count_q;
                        prdata_o[16]     = fifo_empty;
                        prdata_o[17]     = fifo_full;
                    end
                end
                ADDR_CTRL: begin
                    if (!pwrite_i) begin
                        prdata_o[0]    = irq_en_q;
                        prdata_o[15:8] = threshold_q;
                    end
                end
                default: pslverr_o = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_event_fifo_level_int.sv
// Bench for event_fifo_level_int: a depth-4 and a depth-3 instance, each checked
// against a queue-based model through directed steps followed by random traffic.
module tb_event_fifo_level_int;

    localparam logic [7:0] A_DATA = 8'h00;
    localparam logic [7:0] A_STAT = 8'h04;
    localparam logic [7:0] A_CTRL = 8'h08;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  paddr       [2];
    logic [31:0] pwdata      [2];
    logic [31:0] prdata      [2];
    logic        pwrite      [2];
    logic        psel        [2];
    logic        penable     [2];
    logic        pready      [2];
    logic        pslverr     [2];
    logic [7:0]  event_data  [2];
    logic        event_valid [2];
    logic        event_ready [2];
    logic        int_lvl     [2];

    event_fifo_level_int #(.EVENT_WIDTH(8), .FIFO_DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pwrite_i(pwrite[0]),
        .psel_i(psel[0]), .penable_i(penable[0]),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]),
        .event_data_i(event_data[0]), .event_valid_i(event_valid[0]),
        .event_ready_o(event_ready[0]), .int_lvl_o(int_lvl[0])
    );

    event_fifo_level_int #(.EVENT_WIDTH(8), .FIFO_DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pwrite_i(pwrite[1]),
        .psel_i(psel[1]), .penable_i(penable[1]),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]),
        .event_data_i(event_data[1]), .event_valid_i(event_valid[1]),
        .event_ready_o(event_ready[1]), .int_lvl_o(int_lvl[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one event queue per instance plus the CTRL fields.
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         irq_en [2];
    int         thr    [2];
    int         depth  [2] = '{4, 3};

    function automatic int m_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] m_head(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic m_push(input int d, input logic [7:0] x);
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic m_pop(input int d);
        logic [7:0] x;
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
    endtask

    task automatic m_flush(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_flush(d);
            irq_en[d] = 1'b1;
            thr[d]    = 1;
        end
    endtask

    function automatic bit exp_int(input int d);
        int eff;
        eff = thr[d];
        if (eff == 0) eff = 1;
        if (eff > depth[d]) eff = depth[d];
        return irq_en[d] && (m_size(d) >= eff);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int d, input string tag);
        check({tag, ":ready"}, 32'(event_ready[d]), 32'(m_size(d) != depth[d]));
        check({tag, ":int"},   32'(int_lvl[d]),     32'(exp_int(d)));
    endtask

    task automatic push(input int d, input logic [7:0] x, input string tag);
        bit acc;
        @(negedge clk);
        event_valid[d] = 1'b1;
        event_data[d]  = x;
        #1 acc = event_ready[d];
        @(posedge clk);
        #1 event_valid[d] = 1'b0;
        if (acc) m_push(d, x);
        check_outs(d, tag);
    endtask

    task automatic idle(input int d, input string tag);
        @(negedge clk);
        @(posedge clk);
        #1 check_outs(d, tag);
    endtask

    // Two-phase APB transfer; an event can be offered during the access cycle.
    task automatic apb(input int d, input bit wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input bit push_en,
                       input logic [7:0] pdata, input string tag);
        logic [31:0] exp_rd;
        bit          exp_err;
        bit          acc;
        int          n;
        @(negedge clk);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(negedge clk);
        penable[d]     = 1'b1;
        event_valid[d] = push_en;
        event_data[d]  = pdata;
        n       = m_size(d);
        exp_err = !(addr == A_DATA || addr == A_STAT || addr == A_CTRL) ||
                  (wr && addr != A_CTRL);
        exp_rd  = 32'h0;
        if (!wr) begin
            case (addr)
                A_DATA: if (n > 0) exp_rd = 32'h8000_0000 | 32'(m_head(d));
                A_STAT: exp_rd = 32'(n) | ((n == 0) ? 32'h1_0000 : 32'h0) |
                                 ((n == depth[d]) ? 32'h2_0000 : 32'h0);
                A_CTRL: exp_rd = 32'(irq_en[d]) | (32'(thr[d]) << 8);
                default: exp_rd = 32'h0;
            endcase
        end
        #1;
        acc = event_ready[d];
        if (!wr) check({tag, ":rdata"}, prdata[d], exp_rd);
        check({tag, ":pslverr"}, 32'(pslverr[d]), 32'(exp_err));
        @(posedge clk);
        #1;
        psel[d]        = 1'b0;
        penable[d]     = 1'b0;
        event_valid[d] = 1'b0;
        if (!wr && addr == A_DATA && n > 0) m_pop(d);
        if (wr && addr == A_CTRL) begin
            irq_en[d] = wdata[0];
            thr[d]    = int'(wdata[15:8]);
            if (wdata[31]) m_flush(d);
        end
        if (push_en && acc) m_push(d, pdata);
        check_outs(d, tag);
    endtask

    task automatic rd(input int d, input logic [7:0] addr, input string tag);
        apb(d, 1'b0, addr, 32'h0, 1'b0, 8'h00, tag);
    endtask

    task automatic wr(input int d, input logic [7:0] addr, input logic [31:0] data, input string tag);
        apb(d, 1'b1, addr, data, 1'b0, 8'h00, tag);
    endtask

    task automatic random_run(input int d, input int iters);
        logic [31:0] w;
        for (int i = 0; i < iters; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: push(d, 8'($urandom), "rnd_push");
                4, 5, 6:    apb(d, 1'b0, A_DATA, 32'h0, 1'($urandom_range(0, 1)),
                                8'($urandom), "rnd_pop");
                7:          rd(d, A_STAT, "rnd_status");
                8: begin
                    w        = 32'h0;
                    w[31]    = ($urandom_range(0, 7) == 0);
                    w[15:8]  = 8'($urandom_range(0, 5));
                    w[0]     = ($urandom_range(0, 3) != 0);
                    apb(d, 1'b1, A_CTRL, w, 1'($urandom_range(0, 1)), 8'($urandom), "rnd_ctrl");
                end
                default:    idle(d, "rnd_idle");
            endcase
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            paddr[d] = '0; pwdata[d] = '0; pwrite[d] = 1'b0;
            psel[d] = 1'b0; penable[d] = 1'b0;
            event_data[d] = '0; event_valid[d] = 1'b0;
        end
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check_outs(d, "reset");
            check("reset:pready",  32'(pready[d]),  32'h1);
            check("reset:prdata",  prdata[d],       32'h0);
            check("reset:pslverr", 32'(pslverr[d]), 32'h0);
        end
        rd(0, A_STAT, "reset_status");
        rd(0, A_CTRL, "reset_ctrl");

        // Burst fill: int from the first push, ready low after the fourth
        push(0, 8'h11, "fill1");
        push(0, 8'h22, "fill2");
        push(0, 8'h33, "fill3");
        push(0, 8'h44, "fill4");
        push(0, 8'h55, "push_full");
        rd(0, A_STAT, "full_status");
        for (int i = 0; i < 5; i++) rd(0, A_DATA, "drain");

        // Threshold coalescing
        wr(0, A_CTRL, 32'h0000_0301, "thr3");
        push(0, 8'hA1, "thr_push1");
        push(0, 8'hA2, "thr_push2");
        push(0, 8'hA3, "thr_push3");
        rd(0, A_DATA, "thr_pop");
        rd(0, A_DATA, "thr_drain1");
        rd(0, A_DATA, "thr_drain2");

        // Push with a read on an empty FIFO
        apb(0, 1'b0, A_DATA, 32'h0, 1'b1, 8'h5A, "rd_push_empty");
        rd(0, A_STAT, "rd_push_status");

        // Push with a flush
        apb(0, 1'b1, A_CTRL, 32'h8000_0301, 1'b1, 8'h6B, "flush_push");
        rd(0, A_STAT, "flush_status");
        rd(0, A_CTRL, "flush_ctrl");
        rd(0, A_DATA, "flush_data");

        // Interrupt enable
        wr(0, A_CTRL, 32'h0000_0100, "irq_off");
        push(0, 8'h71, "irq_off_push1");
        push(0, 8'h72, "irq_off_push2");
        wr(0, A_CTRL, 32'h0000_0101, "irq_on");

        // Error responses
        wr(0, A_DATA, 32'hFFFF_FFFF, "wr_data");
        wr(0, A_STAT, 32'hFFFF_FFFF, "wr_status");
        rd(0, 8'h0C, "rd_unmapped");
        wr(0, 8'h40, 32'h8000_0000, "wr_unmapped");
        rd(0, A_STAT, "err_status");

        // Reset while full
        push(0, 8'h73, "refill1");
        push(0, 8'h74, "refill2");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_reset();
        for (int d = 0; d < 2; d++) check_outs(d, "midrst");
        rd(0, A_STAT, "midrst_status");
        rd(0, A_CTRL, "midrst_ctrl");

        // Non-power-of-two depth with wrap, then random traffic on both
        push(1, 8'hC1, "d3_push1");
        push(1, 8'hC2, "d3_push2");
        apb(1, 1'b0, A_DATA, 32'h0, 1'b1, 8'hC3, "d3_pop_push");
        push(1, 8'hC4, "d3_push3");
        rd(1, A_STAT, "d3_full_status");
        apb(1, 1'b0, A_DATA, 32'h0, 1'b1, 8'hC5, "d3_pop_full");
        push(1, 8'hC6, "d3_push4");
        rd(1, A_DATA, "d3_pop1");
        rd(1, A_DATA, "d3_pop2");
        rd(1, A_DATA, "d3_pop3");
        random_run(1, 200);
        random_run(0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
